// File: rtl/ball_fsm_if.sv
// Bounce event in, ball state out: the link between game logic and ball_fsm.
interface ball_fsm_if;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [7:0] ball_size_x;
  logic [7:0] ball_size_y;
  logic       ball_dir_x;
  logic       ball_dir_y;
  logic       in_play;
  logic [7:0] rally_count;

  // Game logic side: issues bounce events, observes the ball.
  modport master (
    output bounce,
    input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
    input  ball_dir_x, ball_dir_y, in_play, rally_count
  );

  // Ball owner side.
  modport slave (
    input  bounce,
    output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
    output ball_dir_x, ball_dir_y, in_play, rally_count
  );
endinterface

// File: rtl/ball_fsm.sv
// Ball owner: serve/move FSM, motion tick, bounce hold-off and rally counter.
module ball_fsm #(
  parameter int unsigned SCREEN_X      = 640,
  parameter int unsigned SCREEN_Y      = 480,
  parameter int unsigned BALL_SIZE     = 8,
  parameter int unsigned STEP_X        = 2,
  parameter int unsigned STEP_Y        = 2,
  parameter int unsigned TICK_DIV      = 416667,
  parameter int unsigned SERVE_TICKS   = 60,
  parameter int unsigned HOLDOFF_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  ball_fsm_if.slave  bus
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int unsigned HOLD_W  = $clog2(HOLDOFF_TICKS + 1);
  localparam int unsigned X_MAX   = SCREEN_X - BALL_SIZE;
  localparam int unsigned Y_MAX   = SCREEN_Y - BALL_SIZE;
  localparam int unsigned X_CTR   = X_MAX / 2;
  localparam int unsigned Y_CTR   = Y_MAX / 2;

  localparam logic [0:0] S_SERVE  = 1'b0;
  localparam logic [0:0] S_MOVING = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SERVE_W-1:0] serve_q, serve_d;
  logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               in_play_q, in_play_d;
  logic [7:0]         rally_q, rally_d;
  logic [HOLD_W-1:0]  hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic               armed_x_q, armed_x_d, armed_y_q, armed_y_d;
  logic               tick;

  // One step along an axis in 11-bit signed space, clamped to [0, lim].
  function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic dir,
                                          input logic [10:0] step, input logic [10:0] lim);
    logic signed [10:0] n;
    n = dir ? $signed({1'b0, pos}) + $signed(step)
            : $signed({1'b0, pos}) - $signed(step);
    if (n[10])                 return 10'd0;
    else if (n > $signed(lim)) return lim[9:0];
    else                       return n[9:0];
  endfunction

  assign tick = (tick_q == TICK_W'(TICK_DIV - 1));

  // State and datapath registers; reset re-centres the ball immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_SERVE;
      tick_q    <= '0;
      serve_q   <= '0;
      pos_x_q   <= 10'(X_CTR);
      pos_y_q   <= 10'(Y_CTR);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      in_play_q <= 1'b0;
      rally_q   <= '0;
      hold_x_q  <= '0;
      hold_y_q  <= '0;
      armed_x_q <= 1'b1;
      armed_y_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      serve_q   <= serve_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      in_play_q <= in_play_d;
      rally_q   <= rally_d;
      hold_x_q  <= hold_x_d;
      hold_y_q  <= hold_y_d;
      armed_x_q <= armed_x_d;
      armed_y_q <= armed_y_d;
    end
  end

  // Next-state logic: serve countdown, bounce acceptance and motion.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick ? '0 : tick_q + 1'b1;
    serve_d   = serve_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    rally_d   = rally_q;
    hold_x_d  = hold_x_q;
    hold_y_d  = hold_y_q;
    armed_x_d = armed_x_q;
    armed_y_d = armed_y_q;

    // Re-arm only once the hold-off expired and the same code was released.
    if (hold_x_q == '0 && bus.bounce != 2'b01) armed_x_d = 1'b1;
    if (hold_y_q == '0 && bus.bounce != 2'b10) armed_y_d = 1'b1;

    case (state_q)
      S_SERVE: begin
        if (tick) begin
          if (serve_q == SERVE_W'(SERVE_TICKS - 1)) begin
            state_d = S_MOVING;
            serve_d = '0;
          end else begin
            serve_d = serve_q + 1'b1;
          end
        end
      end
      S_MOVING: begin
        if (bus.bounce == 2'b11) begin
          state_d   = S_SERVE;
          serve_d   = '0;
          pos_x_d   = 10'(X_CTR);
          pos_y_d   = 10'(Y_CTR);
          dir_x_d   = ~dir_x_q;
          rally_d   = '0;
          hold_x_d  = '0;
          hold_y_d  = '0;
          armed_x_d = 1'b1;
          armed_y_d = 1'b1;
        end else begin
          if (tick && hold_x_q != '0) hold_x_d = hold_x_q - 1'b1;
          if (tick && hold_y_q != '0) hold_y_d = hold_y_q - 1'b1;
          if (bus.bounce == 2'b01 && armed_x_q) begin
            dir_x_d   = ~dir_x_q;
            hold_x_d  = HOLD_W'(HOLDOFF_TICKS);
            armed_x_d = 1'b0;
            if (rally_q != 8'hFF) rally_d = rally_q + 8'd1;
          end
          if (bus.bounce == 2'b10 && armed_y_q) begin
            dir_y_d   = ~dir_y_q;
            hold_y_d  = HOLD_W'(HOLDOFF_TICKS);
            armed_y_d = 1'b0;
          end
          // A bounce in the tick cycle already steers this move.
          if (tick) begin
            pos_x_d = step_pos(pos_x_q, dir_x_d, 11'(STEP_X), 11'(X_MAX));
            pos_y_d = step_pos(pos_y_q, dir_y_d, 11'(STEP_Y), 11'(Y_MAX));
          end
        end
      end
      default: state_d = S_SERVE;
    endcase

    in_play_d = (state_d == S_MOVING);
  end

  assign bus.ball_pos_x  = pos_x_q;
  assign bus.ball_pos_y  = pos_y_q;
  assign bus.ball_size_x = 8'(BALL_SIZE);
  assign bus.ball_size_y = 8'(BALL_SIZE);
  assign bus.ball_dir_x  = dir_x_q;
  assign bus.ball_dir_y  = dir_y_q;
  assign bus.in_play     = in_play_q;
  assign bus.rally_count = rally_q;

endmodule

// File: doc/ball_fsm.md
Name: ball_fsm

Overview:
- Consumes the 2-bit bounce event stream from the game logic block and owns the ball's state: position, direction, serve and rally.
- Position and size outputs feed back into the game logic block and into the renderer.
- Moves the ball once per internally generated motion tick.
- Re-serves from the screen centre after a score event.

Parameters:
SCREEN_X, 640, horizontal resolution in pixels
SCREEN_Y, 480, vertical resolution in pixels
BALL_SIZE, 8, ball width and height in pixels
STEP_X, 2, horizontal pixels moved per tick
STEP_Y, 2, vertical pixels moved per tick
TICK_DIV, 416667, clocks per motion tick (60 Hz at 25 MHz)
SERVE_TICKS, 60, ticks the ball rests at centre before launch
HOLDOFF_TICKS, 4, minimum ticks between two accepted bounces on the same axis

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
bounce  input  2  event code: 00 none, 01 paddle, 10 wall, 11 score/re-serve
ball_pos_x  output  10  ball left edge, pixels
ball_pos_y  output  10  ball top edge, pixels
ball_size_x  output  8  constant BALL_SIZE
ball_size_y  output  8  constant BALL_SIZE
ball_dir_x  output  1  1 = moving right (+x), 0 = left
ball_dir_y  output  1  1 = moving down (+y), 0 = up
in_play  output  1  1 while in MOVING state
rally_count  output  8  accepted paddle bounces since last serve, saturating

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values, applied immediately on reset, including mid-play:
  - state SERVE, ball_pos_x=(SCREEN_X-BALL_SIZE)/2 (316), ball_pos_y=(SCREEN_Y-BALL_SIZE)/2 (236)
  - dir_x=1, dir_y=1, in_play=0, rally_count=0
  - tick divider=0, serve counter=0, hold_x=hold_y=0, armed_x=armed_y=1
- Tick generator:
  - counter runs 0..TICK_DIV-1 and wraps
  - tick is asserted for one clock when counter==TICK_DIV-1
  - runs in all states
- State SERVE:
  - position held at centre; bounce is ignored
  - serve counter increments on each tick
  - on the tick where serve counter==SERVE_TICKS-1: go to MOVING, clear serve counter
  - in_play=1 from the next clock; the first move happens on the following tick
- State MOVING, bounce evaluated every clock:
  - 11: next clock go to SERVE; position=centre; dir_x inverted; dir_y kept; rally_count=0; holds cleared; armed flags set. A tick in the same cycle does not move the ball.
  - 01, accepted only if armed_x=1: invert dir_x; hold_x=HOLDOFF_TICKS; armed_x=0; rally_count+1, saturating at 255.
  - 10, accepted only if armed_y=1: invert dir_y; hold_y=HOLDOFF_TICKS; armed_y=0.
  - Unaccepted 01/10 and 00: no direction change.
- Re-arm rule:
  - armed_x is set when hold_x==0 and bounce!=01
  - armed_y is set when hold_y==0 and bounce!=10
  - A held event code therefore produces exactly one inversion.
- On tick in MOVING:
  - hold_x and hold_y decrement if nonzero
  - x moves ±STEP_X and y moves ±STEP_Y using the direction valid after any same-cycle bounce (a bounce coinciding with a tick affects that tick's move)
- Position arithmetic:
  - computed in 11-bit signed space
  - x clamped to [0, SCREEN_X-BALL_SIZE], y clamped to [0, SCREEN_Y-BALL_SIZE]
  - never wraps through 1023
- Direction is never altered by clamping. Only bounce events change direction.
- ball_size_x and ball_size_y are constant BALL_SIZE outputs.

Test Plan:
All scenarios use TICK_DIV=4, SERVE_TICKS=3, HOLDOFF_TICKS=2, STEP_X=STEP_Y=2.
1. Release reset, bounce=00 -> x=316, y=236, in_play=0 for 3 ticks; in_play=1 after the 3rd tick; next tick x=318, y=238.
2. Moving right at x=320, single-clock bounce=01 not on a tick -> dir_x=0, rally_count=1; next tick x=318.
3. Hold bounce=01 for 20 clocks, then 00 for 2 ticks, then 01 again -> exactly one inversion during the hold; second inversion on reassertion; rally_count=2.
4. bounce=01 asserted on the tick cycle with x=318, dir_x=1 -> x=316 on that update, dir_x=0.
5. In MOVING with dir_x=1, rally_count=5, bounce=11 -> next clock x=316, y=236, in_play=0, dir_x=0, rally_count=0; relaunch after 3 ticks.
6. Force y=1 with dir_y=0, then a tick -> y=0, not 1023. Assert reset mid-move -> all outputs return to reset values immediately, without waiting for a clock edge.
